// File: rtl/bram_access_pkg.sv
// Shared definitions for the BRAM access front-end.
// Size codes, lane geometry and the stage-1 bookkeeping record that travels
// alongside each accepted request until its response is presented.
package bram_access_pkg;

    localparam int unsigned NUM_LANES   = 4;
    localparam int unsigned OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        logic                   write;
        size_e                  size;
        logic                   is_unsigned;
        logic [OFFSET_BITS-1:0] off;
        logic                   error;
    } s1_info_t;

endpackage

// File: rtl/bram_access_align.sv
// Purely combinational lane logic for the BRAM access front-end.
// Ports:
//   st_size, st_off, st_wdata -> byte_en, wdata_rep : store side (byte enables,
//                                                    lane-replicated write data)
//   ld_size, ld_off, ld_unsigned, rdata -> ld_data  : load side (shift to lane 0,
//                                                    zero/sign extend)
// Size code 3 is handled as a word on both sides.
module bram_access_align
    import bram_access_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = st_wdata;
        case (st_size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << st_off;
                wdata_rep = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en   = 4'b0011 << st_off;
                wdata_rep = {2{st_wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = st_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}},  shifted[7:0]};
            SIZE_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default:   ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/bram_access_unit.sv
// Load/store request front-end placed directly upstream of a byte-enabled BRAM.
// Ports:
//   clock, reset (async, active-low)
//   req_*   : byte-addressed load/store request, valid/ready handshake
//   resp_*  : one response per request, valid/ready handshake, 1-cycle latency
//   read*/write* : BRAM port (readData valid one cycle after readEnable)
// Build option: BRAM_ACCESS_ALIGN_CHECK_EN rejects misaligned and reserved-size
// requests with resp_error; without it offsets are forced to natural alignment
// and size 3 acts as a word.
module bram_access_unit
    import bram_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  writeEnable,
    output logic [3:0]            writeByteEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData
);

    logic            fire;
    logic            ok;
    logic [1:0]      off;
    logic [1:0]      eff_size;
    logic [1:0]      eff_off;

    logic            s1_valid;
    s1_info_t        s1;
    logic [31:0]     ld_data;
    logic [31:0]     s1_rdata;

    logic            hold_valid;
    logic [31:0]     hold_rdata;
    logic            hold_error;

    assign off = req_address[1:0];

`ifdef BRAM_ACCESS_ALIGN_CHECK_EN
    always_comb begin
        eff_size = req_size;
        eff_off  = off;
        ok = !((req_size == SIZE_RSVD) ||
               (req_size == SIZE_HALF && off[0]) ||
               (req_size == SIZE_WORD && off != 2'b00));
    end
`else
    always_comb begin
        ok       = 1'b1;
        eff_size = (req_size == SIZE_RSVD) ? SIZE_WORD : req_size;
        eff_off  = off;
        if (eff_size == SIZE_HALF)
            eff_off = {off[1], 1'b0};
        else if (eff_size == SIZE_WORD)
            eff_off = 2'b00;
    end
`endif

    // A held response blocks intake; otherwise s1 must be retiring or empty.
    assign req_ready = reset & ~hold_valid & (~s1_valid | resp_ready);
    assign fire      = req_valid & req_ready;

    assign readEnable   = fire & ~req_write & ok;
    assign writeEnable  = fire &  req_write & ok;
    assign readAddress  = req_address[ADDR_WIDTH+1:2];
    assign writeAddress = req_address[ADDR_WIDTH+1:2];

    bram_access_align u_align (
        .st_size     (eff_size),
        .st_off      (eff_off),
        .st_wdata    (req_wdata),
        .byte_en     (writeByteEnable),
        .wdata_rep   (writeData),
        .ld_size     (s1.size),
        .ld_off      (s1.off),
        .ld_unsigned (s1.is_unsigned),
        .rdata       (readData),
        .ld_data     (ld_data)
    );

    assign s1_rdata = (s1.write | s1.error) ? '0 : ld_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1         <= '0;
            hold_valid <= 1'b0;
            hold_rdata <= '0;
            hold_error <= 1'b0;
        end else begin
            // s1 always empties after one cycle: either consumed or moved to hold.
            s1_valid <= fire;
            if (fire) begin
                s1.write       <= req_write;
                s1.size        <= size_e'(eff_size);
                s1.is_unsigned <= req_unsigned;
                s1.off         <= eff_off;
                s1.error       <= ~ok;
            end
            // BRAM output may change once the read has been presented, so a
            // stalled response is frozen here.
            if (hold_valid) begin
                if (resp_ready)
                    hold_valid <= 1'b0;
            end else if (s1_valid && !resp_ready) begin
                hold_valid <= 1'b1;
                hold_rdata <= s1_rdata;
                hold_error <= s1.error;
            end
        end
    end

    assign resp_valid = s1_valid | hold_valid;
    assign resp_rdata = hold_valid ? hold_rdata : (s1_valid ? s1_rdata : '0);
    assign resp_error = hold_valid ? hold_error : (s1_valid & s1.error);

endmodule

// File: tb/tb_bram_access_unit.sv
// Directed self-checking bench for bram_access_unit with a behavioural BRAM.
// Inputs change on the falling edge; outputs are sampled at the falling edge
// (or #1 after it for combinational request-side outputs).
module tb_bram_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_address;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic        readEnable, writeEnable;
    logic [7:0]  readAddress, writeAddress;
    logic [31:0] readData, writeData;
    logic [3:0]  writeByteEnable;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic        scramble = 1'b0;
    logic [31:0] first_rdata;

    always #5 clock = ~clock;

    bram_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData)
    );

    always @(posedge clock) begin
        if (writeEnable)
            for (int b = 0; b < 4; b++)
                if (writeByteEnable[b])
                    mem[writeAddress][8*b +: 8] <= writeData[8*b +: 8];
        if (scramble)
            readData <= $urandom;
        else if (readEnable)
            readData <= mem[readAddress];
    end

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [9:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wd;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if ({readEnable, writeEnable} !== 2'b00) begin failures++; $display("FAIL rst_enables got=%b exp=00", {readEnable, writeEnable}); end
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b/%h/%b exp=0/0/0", resp_valid, resp_rdata, resp_error); end
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); @(negedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rel_resp_valid got=%b exp=0", resp_valid); end
    endtask

    task automatic test_byte;
        resp_ready = 1'b1;
        @(negedge clock);
        drive_req(1'b1, 2'd0, 1'b0, 10'h007, 32'h000000A5);
        #1;
        checks++; if (writeEnable !== 1'b1 || readEnable !== 1'b0) begin failures++; $display("FAIL sb_en got=%b%b exp=10", writeEnable, readEnable); end
        checks++; if (writeAddress !== 8'h01) begin failures++; $display("FAIL sb_addr got=%h exp=01", writeAddress); end
        checks++; if (writeByteEnable !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", writeByteEnable); end
        checks++; if (writeData !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", writeData); end
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin failures++; $display("FAIL sb_resp got=%b/%h/%b exp=1/0/0", resp_valid, resp_rdata, resp_error); end
        drive_req(1'b0, 2'd0, 1'b0, 10'h007, 32'h0);
        #1;
        checks++; if (readEnable !== 1'b1 || readAddress !== 8'h01) begin failures++; $display("FAIL lb_rd got=%b/%h exp=1/01", readEnable, readAddress); end
        @(posedge clock); @(negedge clock);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_signed got=%b/%h exp=1/ffffffa5", resp_valid, resp_rdata); end
        drive_req(1'b0, 2'd0, 1'b1, 10'h007, 32'h0);
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_rdata !== 32'h000000A5) begin failures++; $display("FAIL lb_unsigned got=%h exp=000000a5", resp_rdata); end
    endtask

    task automatic test_half;
        @(negedge clock);
        drive_req(1'b1, 2'd1, 1'b0, 10'h002, 32'h00008001);
        #1;
        checks++; if (writeByteEnable !== 4'b1100 || writeData !== 32'h80018001) begin failures++; $display("FAIL sh_be_data got=%b/%h exp=1100/80018001", writeByteEnable, writeData); end
        @(posedge clock); @(negedge clock);
        drive_req(1'b0, 2'd1, 1'b0, 10'h002, 32'h0);
        #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL sh_resp_valid got=%b exp=1", resp_valid); end
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_signed got=%b/%h exp=1/ffff8001", resp_valid, resp_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h80013344;
        exp_d[1] = 32'hA5667788;
        exp_d[2] = 32'hCAFEF00D;
        resp_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 2'd2, 1'b0, 10'(4 * i), 32'h0);
            #1;
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, req_ready); end
            @(posedge clock); @(negedge clock);
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_d[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, resp_valid, resp_rdata, exp_d[i]); end
        end
        req_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", resp_valid); end
    endtask

    task automatic test_stall;
        @(negedge clock);
        resp_ready = 1'b0;
        drive_req(1'b0, 2'd2, 1'b0, 10'h00C, 32'h0);
        @(posedge clock); @(negedge clock);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADBEEF) begin failures++; $display("FAIL stall_first got=%b/%h exp=1/0badbeef", resp_valid, resp_rdata); end
        drive_req(1'b0, 2'd2, 1'b0, 10'h008, 32'h0);
        scramble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0 || readEnable !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%b/%b exp=0/0", i, req_ready, readEnable); end
            @(posedge clock); @(negedge clock);
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADBEEF) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/0badbeef", i, resp_valid, resp_rdata); end
        end
        resp_ready = 1'b1;
        scramble   = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADBEEF || req_ready !== 1'b0) begin failures++; $display("FAIL stall_release got=%b/%h/%b exp=1/0badbeef/0", resp_valid, resp_rdata, req_ready); end
        @(posedge clock); @(negedge clock); #1;
        checks++; if (req_ready !== 1'b1 || readEnable !== 1'b1) begin failures++; $display("FAIL stall_accept got=%b/%b exp=1/1", req_ready, readEnable); end
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/cafef00d", resp_valid, resp_rdata); end
    endtask

    task automatic test_misaligned;
        logic        exp_re, exp_err;
        logic [31:0] exp_rd;
`ifdef BRAM_ACCESS_ALIGN_CHECK_EN
        exp_re = 1'b0; exp_err = 1'b1; exp_rd = 32'h0;
`else
        exp_re = 1'b1; exp_err = 1'b0; exp_rd = 32'h80013344;
`endif
        @(negedge clock);
        resp_ready = 1'b1;
        drive_req(1'b0, 2'd2, 1'b0, 10'h001, 32'h0);
        #1;
        checks++; if (readEnable !== exp_re) begin failures++; $display("FAIL mis_re got=%b exp=%b", readEnable, exp_re); end
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_error !== exp_err || resp_rdata !== exp_rd) begin failures++; $display("FAIL mis_resp got=%b/%b/%h exp=1/%b/%h", resp_valid, resp_error, resp_rdata, exp_err, exp_rd); end
    endtask

    task automatic test_wrap;
        @(negedge clock);
        drive_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);
        #1;
        checks++; if (readAddress !== 8'hFF || readEnable !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%h/%b exp=ff/1", readAddress, readEnable); end
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wrap_data got=%h exp=deadbeef", resp_rdata); end
    endtask

    task automatic test_reset_midop;
        @(negedge clock);
        resp_ready = 1'b0;
        drive_req(1'b0, 2'd2, 1'b0, 10'h00C, 32'h0);
        @(posedge clock); @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL mid_held got=%b exp=1", resp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", resp_valid, resp_rdata, req_ready); end
        @(negedge clock);
        reset = 1'b1;
        resp_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_after got=%b/%b exp=0/1", resp_valid, req_ready); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h11223344;
        mem[1]   = 32'h55667788;
        mem[2]   = 32'hCAFEF00D;
        mem[3]   = 32'h0BADBEEF;
        mem[255] = 32'hDEADBEEF;
        readData     = 32'h0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_address  = 10'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b1;
        first_rdata  = 32'h0;

        test_reset();
        test_byte();
        test_half();
        test_back_to_back();
        test_stall();
        test_misaligned();
        test_wrap();
        test_reset_midop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_access_unit.md
Name: bram_access_unit

Overview:
- Request front-end that sits directly upstream of the byte-enabled BRAM wrapper.
- Accepts byte-addressed load/store requests (byte/half/word, signed/unsigned) over a valid/ready handshake.
- Drives the BRAM word address, per-byte write enables and lane-replicated write data.
- Aligns and extends returned read data; every request gets exactly one response on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 32, BRAM word width; only 32 is supported (4 byte lanes, 2 offset bits).
- ADDR_WIDTH, 8, BRAM word-address width; the request byte address is ADDR_WIDTH+2 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_address  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or reserved-size request
- readEnable  out  1  to BRAM
- readAddress  out  ADDR_WIDTH  to BRAM; req_address[ADDR_WIDTH+1:2]
- readData  in  32  from BRAM, valid one cycle after readEnable
- writeEnable  out  1  to BRAM
- writeByteEnable  out  4  to BRAM
- writeAddress  out  ADDR_WIDTH  to BRAM
- writeData  out  32  to BRAM

Behaviour:
- Reset: req_ready=0 while reset is low. resp_valid=0, resp_error=0, resp_rdata=0. readEnable=writeEnable=0. s1_valid and hold_valid are cleared.
- Define fire = req_valid & req_ready.
- BRAM enables are combinational from fire:
  - readEnable = fire & ~req_write & ok
  - writeEnable = fire & req_write & ok
  - ok = request is legal (see Optional Feature).
- Byte enables, with off = req_address[1:0]:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- writeData lane replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Pipeline stage s1, registered on fire: s1_valid, write, size, unsigned, off, error.
  - Latency is 1 cycle: resp_valid is asserted the cycle after fire.
- Load extraction from readData:
  - shift right by 8*off;
  - take 8 or 16 bits for byte/half;
  - zero- or sign-extend per s1 unsigned.
  - Stores respond with rdata=0, error=s1 error.
- Skid/hold register:
  - s1_valid & ~resp_ready: the extracted response is captured into hold (hold_valid=1), because BRAM output is not guaranteed stable afterwards.
  - resp_valid = s1_valid | hold_valid.
  - Outputs come from hold when hold_valid, else from s1 and readData combinationally.
- req_ready = reset & ~hold_valid & (~s1_valid | resp_ready). This sustains 1 request/cycle when resp_ready is held high.
- Simultaneous fire and resp handshake in the same cycle: the s1 response retires and the new request enters s1.
- Address wrap: no carry out of the word address; the top of memory is handled like any other word.
- Reset mid-operation: in-flight s1/hold responses are discarded; no response is emitted for them after reset.

Optional Feature:
- Macro BRAM_ACCESS_ALIGN_CHECK_EN.
- Defined:
  - half with off[0]=1, word with off!=0, or size 3 is illegal (ok=0);
  - no BRAM enable is asserted;
  - the response still arrives after 1 cycle with resp_error=1 and resp_rdata=0.
- Undefined:
  - offset is forced to natural alignment (half clears bit 0, word clears both bits);
  - size 3 is treated as word;
  - resp_error is tied to 0.

Decomposition:
- Package bram_access_pkg: size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD, NUM_LANES=4, OFFSET_BITS=2, and the s1 info struct.
- One combinational sub-module, bram_access_align: byte-enable generation, store replication, load shift/extend.
- The pipeline and hold logic stay in the top module.

Test Plan:
- Reset low with req_valid=1 -> req_ready=0, no BRAM enables; release -> req_ready=1 next edge.
- Store byte 0xA5 at address 0x0007 -> writeAddress=1, writeByteEnable=4'b1000, writeData=0xA5A5A5A5. Then signed byte load of 0x0007 -> resp_rdata=0xFFFFFFA5; unsigned load -> 0x000000A5.
- Store half 0x8001 at 0x0002 -> BE=4'b1100. Signed half load at 0x0002 -> 0xFFFF8001, one cycle after fire.
- Back-to-back word loads of 0x0,0x4,0x8 with resp_ready=1 -> three responses on consecutive cycles, data in order.
- Word load with resp_ready=0 for 3 cycles while BRAM readData changes -> resp_rdata stable, req_ready=0 until resp_ready=1, then the next request is accepted.
- Word load at 0x0001:
  - with BRAM_ACCESS_ALIGN_CHECK_EN -> readEnable=0, resp_error=1, rdata=0;
  - without it -> reads word 0, resp_error=0.
